regfile_scoreboard: RTL

//  Banked register file (GPR/FPR and further banks) with NRD synchronous read ports,
//  one write-back port, one debug read port and a busy-bit scoreboard for in-flight results.

---
 rtl/regfile_scoreboard_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 65 ++++++
 2 files changed

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, write-back, issue and debug signals of the banked register file
interface regfile_scoreboard_if #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int NBANK = 2,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREG);
  localparam int BW = NBANK > 1 ? $clog2(NBANK) : 1;
  localparam int PW = $clog2(NREG * NBANK) + 1;
  logic [NRD*BW-1:0]    rd_bank;
  logic [NRD*AW-1:0]    rd_num;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 wr_en;
  logic [BW-1:0]        wr_bank;
  logic [AW-1:0]        wr_num;
  logic [WIDTH-1:0]     wr_data;
  logic                 iss_en;
  logic [BW-1:0]        iss_bank;
  logic [AW-1:0]        iss_num;
  logic                 iss_ready;
  logic [BW-1:0]        dbg_bank;
  logic [AW-1:0]        dbg_num;
  logic [WIDTH-1:0]     dbg_data;
  logic [PW-1:0]        pending;
  modport master (
    output rd_bank, rd_num, wr_en, wr_bank, wr_num, wr_data, iss_en, iss_bank, iss_num, dbg_bank, dbg_num,
    input  rd_data, rd_busy, iss_ready, dbg_data, pending
  );
  modport slave (
    input  rd_bank, rd_num, wr_en, wr_bank, wr_num, wr_data, iss_en, iss_bank, iss_num, dbg_bank, dbg_num,
    output rd_data, rd_busy, iss_ready, dbg_data, pending
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: banked register file with sync read ports, write-back and busy-bit scoreboard
module regfile_scoreboard #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int NBANK = 2,
  parameter int NRD   = 2
) (
  input logic clk,
  input logic rstn,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int BW = NBANK > 1 ? $clog2(NBANK) : 1;
  localparam int NE = NBANK * NREG;
  localparam int IW = NE > 1 ? $clog2(NE) : 1;
  localparam int PW = $clog2(NE) + 1;
  function automatic logic ok(input logic [BW-1:0] b);
    return 32'(b) < NBANK;
  endfunction
  function automatic logic hz(input logic [BW-1:0] b, input logic [AW-1:0] n);
    return b == '0 && n == '0;
  endfunction
  // Flat index; out-of-range banks are mapped to entry 0 and masked by ok() at every use
  function automatic logic [IW-1:0] ix(input logic [BW-1:0] b, input logic [AW-1:0] n);
    return ok(b) ? IW'(32'(b) * NREG + 32'(n)) : '0;
  endfunction
  logic [WIDTH-1:0] mem [NE];
  logic [NE-1:0]    busy, busy_nxt;
  logic             wr_ok, iss_set;
  logic [IW-1:0]    wr_ix, iss_ix;
  always_comb begin
    wr_ix = ix(bus.wr_bank, bus.wr_num);
    iss_ix = ix(bus.iss_bank, bus.iss_num);
    wr_ok = bus.wr_en && ok(bus.wr_bank) && !hz(bus.wr_bank, bus.wr_num);
    bus.iss_ready = ok(bus.iss_bank) &&
                    (!busy[iss_ix] || (bus.wr_en && bus.wr_bank == bus.iss_bank && bus.wr_num == bus.iss_num));
    iss_set = bus.iss_en && bus.iss_ready && !hz(bus.iss_bank, bus.iss_num);
    busy_nxt = busy;
    if (wr_ok) busy_nxt[wr_ix] = 1'b0;
    if (iss_set) busy_nxt[iss_ix] = 1'b1;
    bus.dbg_data = ok(bus.dbg_bank) ? mem[ix(bus.dbg_bank, bus.dbg_num)] : '0;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int e = 0; e < NE; e++) mem[e] <= '0;
    end else if (wr_ok) begin
      mem[wr_ix] <= bus.wr_data;
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      busy <= '0;
      bus.pending <= '0;
      bus.rd_data <= '0;
      bus.rd_busy <= '0;
    end else begin
      busy <= busy_nxt;
      bus.pending <= PW'($countones(busy_nxt));
      for (int p = 0; p < NRD; p++) begin
        bus.rd_data[p*WIDTH +: WIDTH] <= !ok(bus.rd_bank[p*BW +: BW]) ? '0 :
          (wr_ok && wr_ix == ix(bus.rd_bank[p*BW +: BW], bus.rd_num[p*AW +: AW])) ? bus.wr_data :
          mem[ix(bus.rd_bank[p*BW +: BW], bus.rd_num[p*AW +: AW])];
        bus.rd_busy[p] <= ok(bus.rd_bank[p*BW +: BW]) && busy_nxt[ix(bus.rd_bank[p*BW +: BW], bus.rd_num[p*AW +: AW])];
      end
    end
endmodule
